// File: rtl/lfsr_checker_pkg.sv
// ---------------------------------------------------------------------------
// lfsr_checker_pkg
// Shared definitions for the PRBS26 generator/checker pair:
//   LFSR_W     - sequence register width (26)
//   LFSR_TAPS  - feedback taps of x^26+x^6+x^2+x+1, expressed as the
//                sequence lags {26,25,24,20}: b[n] = XOR of b[n-tap]
//   FILL_W     - width of a counter able to hold 0..LFSR_W
//   state_t    - checker FSM encoding (HUNT, CHECK)
// ---------------------------------------------------------------------------
package lfsr_checker_pkg;

  localparam int LFSR_W = 26;
  localparam int N_TAPS = 4;
  localparam int LFSR_TAPS [N_TAPS] = '{26, 25, 24, 20};
  localparam int FILL_W = $clog2(LFSR_W + 1);

  typedef enum logic {
    HUNT  = 1'b0,
    CHECK = 1'b1
  } state_t;

endpackage

// File: rtl/lfsr_checker_predict.sv
// ---------------------------------------------------------------------------
// lfsr_predict
// Combinational next-bit predictor for the PRBS26 recurrence.
// Ports:
//   hist - last LFSR_W accepted bits, hist[0] newest, hist[k-1] = b[n-k]
//   pred - predicted next bit b[n]
// ---------------------------------------------------------------------------
module lfsr_predict
  import lfsr_checker_pkg::*;
(
  input  logic [LFSR_W-1:0] hist,
  output logic              pred
);

  logic [N_TAPS-1:0] tap_bits;

  // Lag k lives at hist[k-1] because hist[0] holds the most recent bit.
  for (genvar gi = 0; gi < N_TAPS; gi++) begin : g_tap
    assign tap_bits[gi] = hist[LFSR_TAPS[gi]-1];
  end

  assign pred = ^tap_bits;

endmodule

// File: rtl/lfsr_checker.sv
// ---------------------------------------------------------------------------
// lfsr_checker
// PRBS26 receive checker. Hunts for 26 non-zero bits, then predicts every
// following bit from its own history and flags mismatches. Too many
// mismatches inside one window drops lock and restarts the hunt.
// Parameters:
//   LOSS_THRESH - mismatches within one window that force loss of lock
//   WINDOW      - error-window length in checked bits
//   CNT_W       - error counter width
// Ports:
//   clk       - clock, rising edge
//   rst       - synchronous active-high reset
//   din       - received serial bit
//   din_valid - din is sampled only when high; low freezes all state
//   clr       - synchronous clear of err_cnt
//   locked    - high while in CHECK
//   err       - one-cycle pulse, one cycle after a mismatching bit
//   err_cnt   - saturating mismatch count
// Build option:
//   LFSR_CHK_ERRCNT_EN - when defined, err_cnt/clr are implemented;
//                        otherwise err_cnt is tied to 0 and clr ignored.
// ---------------------------------------------------------------------------
module lfsr_checker
  import lfsr_checker_pkg::*;
#(
  parameter int LOSS_THRESH = 4,
  parameter int WINDOW      = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  input  logic             clr,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int WIN_W   = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int TALLY_W = $clog2(LOSS_THRESH + 1);

  localparam logic [FILL_W-1:0]  FILL_FULL    = FILL_W'(LFSR_W);
  localparam logic [WIN_W-1:0]   WIN_LAST     = WIN_W'(WINDOW - 1);
  localparam logic [TALLY_W-1:0] TALLY_THRESH = TALLY_W'(LOSS_THRESH);

  state_t              state_reg, state_next;
  logic [LFSR_W-1:0]   hist_reg,  hist_next;
  logic [FILL_W-1:0]   fill_reg,  fill_next;
  logic [WIN_W-1:0]    win_reg,   win_next;
  logic [TALLY_W-1:0]  tally_reg, tally_next;
  logic [TALLY_W-1:0]  tally_sum;
  logic                err_reg;
  logic                pred;
  logic                mismatch;

  lfsr_predict u_predict (
    .hist (hist_reg),
    .pred (pred)
  );

  always_comb begin
    state_next = state_reg;
    hist_next  = hist_reg;
    fill_next  = fill_reg;
    win_next   = win_reg;
    tally_next = tally_reg;
    tally_sum  = tally_reg;
    mismatch   = 1'b0;
    if (din_valid) begin
      if (state_reg == HUNT) begin
        hist_next = {hist_reg[LFSR_W-2:0], din};
        if (fill_reg != FILL_FULL) begin
          fill_next = fill_reg + FILL_W'(1);
        end
        // An all-zero history is the LFSR lock-up state: keep hunting with
        // fill parked at full until a non-zero bit arrives.
        if ((fill_next == FILL_FULL) && (hist_next != '0)) begin
          state_next = CHECK;
          win_next   = '0;
          tally_next = '0;
        end
      end else begin
        mismatch  = din ^ pred;
        // Shift the prediction, not din, so a line error never pollutes
        // the history used for later predictions.
        hist_next = {hist_reg[LFSR_W-2:0], pred};
        // The bit that wraps the window opens the new window, so its
        // mismatch is the first one of the fresh tally.
        if (win_reg == WIN_LAST) begin
          win_next  = '0;
          tally_sum = TALLY_W'(mismatch);
        end else begin
          win_next  = win_reg + WIN_W'(1);
          tally_sum = tally_reg + TALLY_W'(mismatch);
        end
        if (tally_sum >= TALLY_THRESH) begin
          state_next = HUNT;
          fill_next  = '0;
          win_next   = '0;
          tally_next = '0;
        end else begin
          tally_next = tally_sum;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= HUNT;
      hist_reg  <= '0;
      fill_reg  <= '0;
      win_reg   <= '0;
      tally_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      hist_reg  <= hist_next;
      fill_reg  <= fill_next;
      win_reg   <= win_next;
      tally_reg <= tally_next;
      err_reg   <= mismatch;
    end
  end

  assign locked = (state_reg == CHECK);
  assign err    = err_reg;

`ifdef LFSR_CHK_ERRCNT_EN
  logic [CNT_W-1:0] cnt_reg;

  // Counted on the same edge that raises err, so err_cnt already includes
  // the pulse while it is visible; clr on that edge wins.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_reg <= '0;
    end else if (mismatch && (cnt_reg != '1)) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  assign err_cnt = cnt_reg;
`else
  logic unused_clr;
  assign unused_clr = clr;
  assign err_cnt    = '0;
`endif

endmodule

// File: tb/tb_lfsr_checker.sv
// ---------------------------------------------------------------------------
// tb_lfsr_checker
// Self-checking bench: a PRBS26 stream is built from the recurrence, fed to
// the checker with directed error injection and randomized valid gaps, and
// every cycle is compared against a queue-based reference of the checker.
// ---------------------------------------------------------------------------
module tb_lfsr_checker;

  localparam int TB_THRESH = 4;
  localparam int TB_WINDOW = 64;
  localparam int TB_CNT_W  = 4;
  localparam int CNT_MAX   = (1 << TB_CNT_W) - 1;
  localparam int STREAM_N  = 4096;
`ifdef LFSR_CHK_ERRCNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                din = 1'b0;
  logic                din_valid = 1'b0;
  logic                clr = 1'b0;
  logic                locked;
  logic                err;
  logic [TB_CNT_W-1:0] err_cnt;

  lfsr_checker #(
    .LOSS_THRESH (TB_THRESH),
    .WINDOW      (TB_WINDOW),
    .CNT_W       (TB_CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .clr       (clr),
    .locked    (locked),
    .err       (err),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // PRBS26 source stream
  bit stream [STREAM_N];
  int sp = 0;

  // Reference model of the checker
  bit m_lock;
  int m_fill;
  bit hq[$];          // hq[0] = b[n-26] ... hq[25] = b[n-1]
  int m_checked;
  int m_tally;
  bit m_err;
  int m_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_update(input bit v, input bit d, input bit c, input bit r);
    bit mis;
    bit any;
    bit pred;
    mis = 1'b0;
    if (r) begin
      m_lock = 0; m_fill = 0; m_checked = 0; m_tally = 0; m_err = 0; m_cnt = 0;
      hq.delete();
      repeat (26) hq.push_back(1'b0);
    end else begin
      if (v) begin
        if (!m_lock) begin
          hq.push_back(d);
          void'(hq.pop_front());
          if (m_fill < 26) m_fill++;
          any = 1'b0;
          foreach (hq[i]) any |= hq[i];
          if (m_fill == 26 && any) begin
            m_lock = 1; m_checked = 0; m_tally = 0;
          end
        end else begin
          pred = hq[0] ^ hq[1] ^ hq[2] ^ hq[6];
          mis  = d ^ pred;
          hq.push_back(pred);
          void'(hq.pop_front());
          if (((m_checked + 1) % TB_WINDOW) == 0) m_tally = 0;
          m_tally += int'(mis);
          m_checked++;
          if (m_tally >= TB_THRESH) begin
            m_lock = 0; m_fill = 0;
          end
        end
      end
      m_err = mis;
      if (c) m_cnt = 0;
      else if (mis && m_cnt < CNT_MAX) m_cnt++;
      if (!CNT_EN) m_cnt = 0;
    end
  endtask

  task automatic step(input bit v, input bit d, input bit c, input bit r);
    din_valid = v; din = d; clr = c; rst = r;
    @(posedge clk);
    model_update(v, d, c, r);
    #1;
    check("locked",  32'(locked),  32'(m_lock));
    check("err",     32'(err),     32'(m_err));
    check("err_cnt", 32'(err_cnt), 32'(m_cnt));
    $display("t=%0t v=%0b din=%0b clr=%0b rst=%0b -> locked=%0b err=%0b err_cnt=%0d",
             $time, v, d, c, r, locked, err, err_cnt);
  endtask

  // Valid cycles consume the next stream bit (optionally inverted);
  // idle cycles present random junk on din.
  task automatic send(input bit v, input bit inv, input bit c, input bit r);
    bit d;
    if (v && !r) begin
      d = stream[sp] ^ inv;
      sp++;
    end else begin
      d = 1'($urandom);
    end
    step(v, d, c, r);
  endtask

  initial begin
    logic [25:0] seed;
    int nvalid;
    bit v;
    seed = 26'b11011001010110101101011001;
    for (int i = 0; i < STREAM_N; i++) begin
      if (i < 26) stream[i] = seed[25-i];
      else        stream[i] = stream[i-26] ^ stream[i-25] ^ stream[i-24] ^ stream[i-20];
    end

    // Reset state
    send(0, 0, 0, 1);
    send(0, 0, 0, 1);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);

    // Acquisition: lock on exactly the 26th valid bit
    for (int i = 0; i < 26; i++) begin
      send(1, 0, 0, 0);
      if (i == 24) check("lock_not_at_25", 32'(locked), 32'd0);
      if (i == 25) check("lock_at_26", 32'(locked), 32'd1);
    end
    while (sp < 100) send(1, 0, 0, 0);

    // Single error at bit index 100
    send(1, 1, 0, 0);
    check("single_err_pulse", 32'(err), 32'd1);
    check("single_err_cnt", 32'(err_cnt), CNT_EN ? 32'd1 : 32'd0);
    check("single_err_locked", 32'(locked), 32'd1);
    send(1, 0, 0, 0);
    check("single_err_one_cycle", 32'(err), 32'd0);

    // Three errors closing one window, three opening the next: no loss
    while (sp < 214) send(1, 0, 0, 0);
    repeat (6) send(1, 1, 0, 0);
    check("wrap_err_new_window", 32'(locked), 32'd1);

    // Clear, then four errors inside one window force loss of lock
    while (sp < 282) send(1, 0, 0, 0);
    send(1, 0, 1, 0);
    check("clr_zero", 32'(err_cnt), 32'd0);
    while (sp <= 316) send(1, (sp == 286 || sp == 296 || sp == 306 || sp == 316), 0, 0);
    check("loss_locked", 32'(locked), 32'd0);
    check("loss_err_pulse", 32'(err), 32'd1);
    check("loss_err_cnt", 32'(err_cnt), CNT_EN ? 32'd4 : 32'd0);
    for (int i = 0; i < 26; i++) begin
      send(1, 0, 0, 0);
      if (i == 24) check("relock_not_at_25", 32'(locked), 32'd0);
      if (i == 25) check("relock_at_26", 32'(locked), 32'd1);
    end

    // Randomized valid gaps, errors and clears against the model
    for (int i = 0; i < 600; i++) begin
      v = ($urandom_range(0, 3) != 0);
      send(v, v && ($urandom_range(0, 39) == 0), v && ($urandom_range(0, 49) == 0), 0);
    end

    // All-zero input never locks and never flags
    send(0, 0, 0, 1);
    for (int i = 0; i < 40; i++) begin
      step(1, 0, 0, 0);
      check("zeros_locked", 32'(locked), 32'd0);
      check("zeros_err", 32'(err), 32'd0);
    end

    // Counter saturation, then clr coincident with an error
    send(0, 0, 0, 1);
    repeat (26) send(1, 0, 0, 0);
    check("sat_locked", 32'(locked), 32'd1);
    for (int e = 0; e < 20; e++) begin
      send(1, 1, 0, 0);
      repeat (29) send(1, 0, 0, 0);
    end
    check("sat_err_cnt", 32'(err_cnt), CNT_EN ? 32'd15 : 32'd0);
    check("sat_still_locked", 32'(locked), 32'd1);
    send(1, 1, 1, 0);
    check("clr_with_err_pulse", 32'(err), 32'd1);
    check("clr_with_err_cnt", 32'(err_cnt), 32'd0);

    // Reset mid-CHECK with din_valid toggling
    for (int i = 0; i < 10; i++) send(i % 2 == 0, 0, 0, 0);
    check("pre_rst_locked", 32'(locked), 32'd1);
    send(1, 1, 0, 0);
    send(1'($urandom), 0, 0, 1);
    check("mid_rst_locked", 32'(locked), 32'd0);
    check("mid_rst_err", 32'(err), 32'd0);
    check("mid_rst_err_cnt", 32'(err_cnt), 32'd0);
    nvalid = 0;
    while (nvalid < 26) begin
      v = (nvalid % 3 == 0) ? 1'b1 : 1'($urandom);
      send(v, 0, 0, 0);
      if (v) begin
        nvalid++;
        if (nvalid == 25) check("rst_relock_not_at_25", 32'(locked), 32'd0);
        if (nvalid == 26) check("rst_relock_at_26", 32'(locked), 32'd1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
